ifetch_unit: RTL

Sequential instruction-fetch stage that sits directly upstream of the decode/control logic in the RV32I core. It owns the fetch PC and runs a request/response handshake with instruction memory, allowing one outstanding request. Fetched words go into a 2-entry queue and are presented to decode with a valid/ready handshake. It consumes the controller's `PCSrc` and the datapath's `PCTarget` to redirect fetch, discarding any in-flight or queued wrong-path instructions.

---
 rtl/ifetch_pkg.sv | 27 ++
 rtl/ifetch_if.sv | 36 +++
 rtl/ifetch_queue.sv | 78 +++++++
 rtl/ifetch_unit.sv | 136 +++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared definitions for the instruction-fetch stage.
//   - fetch_state_e : fetch FSM states (StTrap exists only with IFETCH_MISALIGN_TRAP_EN)
//   - INSTR_W       : instruction word width
//   - QDEPTH        : fetch queue depth
//   - QCNT_W        : width of the queue occupancy count
//   - RESET_PC_DEFAULT : default first fetch address after reset
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN.
package ifetch_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam int unsigned QDEPTH           = 2;
    localparam int unsigned QCNT_W           = 2;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
`ifdef IFETCH_MISALIGN_TRAP_EN
        StDrop,
        StTrap
`else
        StDrop
`endif
    } fetch_state_e;

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: instruction-memory request/response bus.
//   imem_req    : fetch request valid (fetch -> memory)
//   imem_addr   : word-aligned fetch address (fetch -> memory)
//   imem_gnt    : request accepted this cycle (memory -> fetch)
//   imem_rvalid : response data valid (memory -> fetch)
//   imem_rdata  : instruction word (memory -> fetch)
// Modports: master (fetch unit), slave (memory).
interface ifetch_if
    import ifetch_pkg::*;
#(
    parameter int unsigned XLEN = 32
);

    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: 2-entry FIFO of {instr, pc} between fetch and decode.
//   clk, reset     : clock, synchronous active-high reset
//   i_push         : write {i_instr, i_pc} at the tail
//   i_pop          : drop the head entry
//   i_flush        : empty the queue; wins over a same-cycle push
//   o_count        : current occupancy (0..2)
//   o_head_instr   : head instruction word
//   o_head_pc      : head instruction address
// Entry 0 is always the head, so the head outputs come straight from registers.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [XLEN-1:0]    i_pc,
    output logic [QCNT_W-1:0]  o_count,
    output logic [INSTR_W-1:0] o_head_instr,
    output logic [XLEN-1:0]    o_head_pc
);

    logic [INSTR_W-1:0] r_instr [QDEPTH];
    logic [XLEN-1:0]    r_pc    [QDEPTH];
    logic [QCNT_W-1:0]  r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_instr[i] <= '0;
                r_pc[i]    <= '0;
            end
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == '0) begin
                        r_instr[0] <= i_instr;
                        r_pc[0]    <= i_pc;
                    end else begin
                        r_instr[1] <= i_instr;
                        r_pc[1]    <= i_pc;
                    end
                    r_count <= r_count + QCNT_W'(1);
                end
                2'b01: begin
                    r_instr[0] <= r_instr[1];
                    r_pc[0]    <= r_pc[1];
                    r_count    <= r_count - QCNT_W'(1);
                end
                2'b11: begin
                    // Occupancy unchanged: new word lands right behind the surviving entry.
                    if (r_count == QCNT_W'(1)) begin
                        r_instr[0] <= i_instr;
                        r_pc[0]    <= i_pc;
                    end else begin
                        r_instr[0] <= r_instr[1];
                        r_pc[0]    <= r_pc[1];
                        r_instr[1] <= i_instr;
                        r_pc[1]    <= i_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count      = r_count;
    assign o_head_instr = r_instr[0];
    assign o_head_pc    = r_pc[0];

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: RV32I instruction-fetch stage with one outstanding memory request.
//   clk, reset          : clock, synchronous active-high reset
//   imem (master)       : request/grant + response bus to instruction memory
//   instr_valid/ready   : valid/ready handshake towards decode
//   Instr, PC, PCPlus4  : head instruction, its address and address + 4
//   PCSrc, PCTarget     : redirect request/target, honoured only on an accepted head
//   misalign_trap       : sticky misaligned-target flag (IFETCH_MISALIGN_TRAP_EN only)
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset,
    ifetch_if.master           imem,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] Instr,
    output logic [XLEN-1:0]    PC,
    output logic [XLEN-1:0]    PCPlus4,
    input  logic               PCSrc,
`ifdef IFETCH_MISALIGN_TRAP_EN
    output logic               misalign_trap,
`endif
    input  logic [XLEN-1:0]    PCTarget
);

    fetch_state_e      r_state, w_state_nxt;
    logic [XLEN-1:0]   r_fpc, w_fpc_nxt;
    logic [QCNT_W-1:0] w_count;
    logic              w_req, w_accept, w_redirect, w_outstanding, w_push, w_flush;

    assign instr_valid = (w_count != '0);
    assign w_accept    = instr_valid & instr_ready;
    assign w_redirect  = w_accept & PCSrc;
    // Decoded from state and occupancy only; no path from the decode-side inputs.
    assign w_req       = (r_state == StReq) && (w_count < QCNT_W'(QDEPTH));
    // A response is still owed by memory after this edge.
    assign w_outstanding = ((r_state == StWait) && !imem.imem_rvalid) ||
                           (w_req && imem.imem_gnt);

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_fpc;
    assign PCPlus4        = PC + XLEN'(4);

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic r_trap, w_trap_nxt, w_misalign;
    assign w_misalign    = (PCTarget[1:0] != 2'b00);
    assign misalign_trap = r_trap;
`else
    logic w_unused_tgt_lsb;
    assign w_unused_tgt_lsb = ^PCTarget[1:0];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_fpc_nxt   = r_fpc;
        w_push      = 1'b0;
        w_flush     = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        w_trap_nxt  = r_trap;
`endif
        case (r_state)
            StIdle: w_state_nxt = StReq;
            StReq: begin
                if (w_req && imem.imem_gnt) w_state_nxt = StWait;
            end
            StWait: begin
                if (imem.imem_rvalid) begin
                    w_push      = 1'b1;
                    w_fpc_nxt   = r_fpc + XLEN'(4);
                    w_state_nxt = StReq;
                end
            end
            StDrop: begin
`ifdef IFETCH_MISALIGN_TRAP_EN
                if (imem.imem_rvalid) w_state_nxt = r_trap ? StTrap : StReq;
`else
                if (imem.imem_rvalid) w_state_nxt = StReq;
`endif
            end
`ifdef IFETCH_MISALIGN_TRAP_EN
            StTrap: ;
`endif
            default: w_state_nxt = StIdle;
        endcase

        // Redirect overrides everything above, including a same-cycle response push.
        if (w_redirect) begin
            w_flush     = 1'b1;
            w_push      = 1'b0;
            w_fpc_nxt   = {PCTarget[XLEN-1:2], 2'b00};
            w_state_nxt = w_outstanding ? StDrop : StReq;
`ifdef IFETCH_MISALIGN_TRAP_EN
            if (w_misalign) begin
                w_trap_nxt = 1'b1;
                if (!w_outstanding) w_state_nxt = StTrap;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_fpc   <= RESET_PC;
`ifdef IFETCH_MISALIGN_TRAP_EN
            r_trap  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_fpc   <= w_fpc_nxt;
`ifdef IFETCH_MISALIGN_TRAP_EN
            r_trap  <= w_trap_nxt;
`endif
        end
    end

    ifetch_queue #(
        .XLEN (XLEN)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_pop        (w_accept),
        .i_flush      (w_flush),
        .i_instr      (imem.imem_rdata),
        .i_pc         (r_fpc),
        .o_count      (w_count),
        .o_head_instr (Instr),
        .o_head_pc    (PC)
    );

endmodule
